// File: rtl/prbs31_pkg.sv
// rtl/prbs31_pkg.sv - shared types, taps and LFSR step function for the PRBS31 checker
// Contents:
//   prbs31_state_t  checker state {FILL, VERIFY, LOCKED}
//   PRBS31_TAP_A/B  history taps for x^31 + x^28 + 1 (bit 0 is the newest bit)
//   prbs31_next8    advances 31 bits of history by 8 steps, MSB-first bits out
package prbs31_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs31_state_t;

  localparam int PRBS31_TAP_A = 30;
  localparam int PRBS31_TAP_B = 27;

  typedef struct packed {
    logic [30:0] state;
    logic [7:0]  bits;
  } prbs31_step_t;

  // bits[7] is the first (oldest) predicted bit of the byte.
  function automatic prbs31_step_t prbs31_next8(input logic [30:0] i_state);
    prbs31_step_t r_res;
    logic [30:0]  r_hist;
    logic         r_bit;
    r_hist     = i_state;
    r_res.bits = '0;
    for (int i = 7; i >= 0; i--) begin
      r_bit      = r_hist[PRBS31_TAP_A] ^ r_hist[PRBS31_TAP_B];
      r_hist     = {r_hist[29:0], r_bit};
      r_res.bits[i] = r_bit;
    end
    r_res.state = r_hist;
    return r_res;
  endfunction

endpackage

// File: rtl/prbs31_popcnt8.sv
// rtl/prbs31_popcnt8.sv - combinational 8-bit population count
// Ports:
//   i_bits   in  8  bits to count
//   o_count  out 4  number of ones in i_bits (0..8)
module prbs31_popcnt8 (
  input  logic [7:0] i_bits,
  output logic [3:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_bits[i]};
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - byte-wide PRBS31 checker: self-seed, verify, lock, count bit errors
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      asynchronous active-low reset
//   clear       in  1      synchronous clear of err_count/err_sat/beat_err (and beat_count)
//   in_data     in  8      received byte, in_data[7] oldest bit
//   in_valid    in  1      in_data carries a beat this cycle
//   locked      out 1      checker is in LOCKED
//   err_count   out CNT_W  saturating bit-error total while LOCKED
//   err_sat     out 1      sticky, err_count reached all-ones
//   beat_err    out 4      bit errors of the last beat, held between beats
//   beat_count  out 32     only with PRBS31_CHK_BEAT_CNT_EN: wrapping count of beats seen while LOCKED
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_BEATS = 8,
  parameter int WIN_BEATS  = 32,
  parameter int LOSS_ERRS  = 16,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             locked,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sat,
  output logic [3:0]       beat_err
`ifdef PRBS31_CHK_BEAT_CNT_EN
  ,
  output logic [31:0]      beat_count
`endif
);

  localparam logic [7:0]  LP_LOCK = 8'(LOCK_BEATS);
  localparam logic [8:0]  LP_WIN  = 9'(WIN_BEATS);
  localparam logic [11:0] LP_LOSS = 12'(LOSS_ERRS);

  prbs31_state_t    r_state, w_state_nx;
  // Shared register: raw bit history in FILL, reference LFSR in VERIFY/LOCKED.
  logic [30:0]      r_lfsr, w_lfsr_nx;
  logic [2:0]       r_fill_cnt, w_fill_nx;
  logic [7:0]       r_ok_cnt, w_ok_nx;
  logic [8:0]       r_win_cnt, w_win_cnt_nx;
  logic [11:0]      r_win_sum, w_win_sum_nx;
  logic [CNT_W-1:0] r_err_count;
  logic             r_err_sat;
  logic [3:0]       r_beat_err, w_beat_err_nx;
  logic [3:0]       w_err_add;

  prbs31_step_t     w_step;
  logic [3:0]       w_pop;
  logic [30:0]      w_h_shift;
  logic [2:0]       w_fill_inc;
  logic [8:0]       w_win_inc;
  logic [11:0]      w_win_add;
  logic [CNT_W:0]   w_err_sum;
  logic [CNT_W-1:0] w_err_next;

  assign w_step     = prbs31_next8(r_lfsr);
  assign w_h_shift  = {r_lfsr[22:0], in_data};
  assign w_fill_inc = (r_fill_cnt == 3'd4) ? 3'd4 : r_fill_cnt + 3'd1;
  assign w_win_inc  = r_win_cnt + 9'd1;
  assign w_win_add  = r_win_sum + {8'b0, w_pop};

  prbs31_popcnt8 u_popcnt (
    .i_bits  (in_data ^ w_step.bits),
    .o_count (w_pop)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_lfsr_nx     = r_lfsr;
    w_fill_nx     = r_fill_cnt;
    w_ok_nx       = r_ok_cnt;
    w_win_cnt_nx  = r_win_cnt;
    w_win_sum_nx  = r_win_sum;
    w_beat_err_nx = r_beat_err;
    w_err_add     = 4'd0;
    if (in_valid) begin
      case (r_state)
        FILL: begin
          w_lfsr_nx     = w_h_shift;
          w_fill_nx     = w_fill_inc;
          w_beat_err_nx = 4'd0;
          // An all-zero history would seed a stuck LFSR, so keep filling.
          if (w_fill_inc == 3'd4 && w_h_shift != '0) begin
            w_state_nx = VERIFY;
            w_ok_nx    = 8'd0;
          end
        end
        VERIFY: begin
          w_lfsr_nx     = w_step.state;
          w_beat_err_nx = w_pop;
          if (w_pop != 4'd0) begin
            w_state_nx = FILL;
            w_fill_nx  = 3'd0;
          end else if (r_ok_cnt + 8'd1 == LP_LOCK) begin
            w_state_nx   = LOCKED;
            w_win_cnt_nx = 9'd0;
            w_win_sum_nx = 12'd0;
          end else begin
            w_ok_nx = r_ok_cnt + 8'd1;
          end
        end
        LOCKED: begin
          w_lfsr_nx     = w_step.state;
          w_beat_err_nx = w_pop;
          w_err_add     = w_pop;
          if (w_win_inc == LP_WIN) begin
            w_win_cnt_nx = 9'd0;
            w_win_sum_nx = 12'd0;
            if (w_win_add >= LP_LOSS) begin
              w_state_nx = FILL;
              w_fill_nx  = 3'd0;
            end
          end else begin
            w_win_cnt_nx = w_win_inc;
            w_win_sum_nx = w_win_add;
          end
        end
        default: begin
          w_state_nx = FILL;
          w_fill_nx  = 3'd0;
        end
      endcase
    end
  end

  assign w_err_sum  = {1'b0, r_err_count} + {{(CNT_W-3){1'b0}}, w_err_add};
  assign w_err_next = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_lfsr      <= '0;
      r_fill_cnt  <= '0;
      r_ok_cnt    <= '0;
      r_win_cnt   <= '0;
      r_win_sum   <= '0;
      r_err_count <= '0;
      r_err_sat   <= 1'b0;
      r_beat_err  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_lfsr     <= w_lfsr_nx;
      r_fill_cnt <= w_fill_nx;
      r_ok_cnt   <= w_ok_nx;
      r_win_cnt  <= w_win_cnt_nx;
      r_win_sum  <= w_win_sum_nx;
      // clear discards the current beat's errors; the FSM above still sees the beat.
      if (clear) begin
        r_err_count <= '0;
        r_err_sat   <= 1'b0;
        r_beat_err  <= '0;
      end else if (in_valid) begin
        r_err_count <= w_err_next;
        r_err_sat   <= r_err_sat | (&w_err_next);
        r_beat_err  <= w_beat_err_nx;
      end
    end
  end

`ifdef PRBS31_CHK_BEAT_CNT_EN
  logic [31:0] r_beat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_count <= '0;
    end else if (clear) begin
      r_beat_count <= '0;
    end else if (in_valid && r_state == LOCKED) begin
      r_beat_count <= r_beat_count + 32'd1;
    end
  end

  assign beat_count = r_beat_count;
`endif

  assign locked    = (r_state == LOCKED);
  assign err_count = r_err_count;
  assign err_sat   = r_err_sat;
  assign beat_err  = r_beat_err;

endmodule
